irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Z80 IM2 interrupt controller sitting between peripheral IRQ sources (uart, usb_interface, sd_interface, video, gpio) and the tv80s int_n input.
- Edge-captures up to NUM_SRC requests, applies per-source masking and fixed priority, and drives int_n.
- Supplies the IM2 vector during the CPU acknowledge cycle (M1 and IORQ both low).
- Tracks in-service state until software writes EOI.
- Register access through addr_decoder chip select, same bus signals as the other peripherals.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..8); index 0 has highest priority.

Ports:
clk_i  in  1  system clock.
rst_i  in  1  synchronous reset, active-high.
wr_n  in  1  CPU write strobe, active low.
m1_n  in  1  CPU M1, active low.
iorq_n  in  1  CPU IORQ, active low.
reg_addr_i  in  3  register select (cpu_addr[2:0]).
data_i  in  8  CPU write data.
intc_cs  in  1  chip select from addr_decoder (I/O space).
data_o  out  8  register read data, or vector while int_ack_o=1.
irq_i  in  NUM_SRC  peripheral requests, active high, synchronous to clk_i.
int_n_o  out  1  to CPU int_n, active low.
int_ack_o  out  1  high during acknowledge; top-level mux selects data_o ahead of all other sources.

Behaviour:
- Reset: all outputs are synchronous to clk_i; reset is synchronous, active-high. Values in reset: PEND=0, MASK=0, VBASE=0, GIE=0, ISR=0, int_n_o=1, int_ack_o=0, data_o=0, state=IDLE, irq_q=0. Asserting rst_i mid-acknowledge returns to IDLE with the same values.
- Writes: a write takes effect once per access, on the first cycle where intc_cs=1 and wr_n=0 (registered strobe edge-detect). Held strobes do not repeat W1C or EOI.
- Register map (reg_addr_i):
  - 0 PEND: R = pending bits; W = write-1-to-clear.
  - 1 MASK: R/W; bit=1 enables the source.
  - 2 VBASE: bits 7:5 R/W; read bits 4:0 = 0.
  - 3 CTRL: W bit7 = GIE, W bit0 = 1 → EOI. R = {GIE, ~int_n_o, 3'b0, cur_idx[2:0]}.
  - 4 ISR: read-only in-service bits.
  - 5..7: read 0, writes ignored.
  - Bits above NUM_SRC read 0.
- Capture: PEND[i] sets on the clock edge where irq_i[i]=1 and irq_q[i]=0. An edge arriving in the same cycle as a W1C or acknowledge-clear of that bit wins; the bit stays 1.
- Eligibility:
  - eligible = PEND & MASK, with GIE=1.
  - Source i is blocked if any ISR bit with index ≤ i is set (no-nesting build: any ISR bit set).
  - cur_idx = lowest eligible index.
- State machine:
  - IDLE: if any eligible, int_n_o←0 and go to REQ. int_n_o therefore falls 2 edges after irq_i rises.
  - REQ: int_n_o held 0. If eligibility vanishes before ack (masked, cleared, GIE=0), int_n_o←1 and go to IDLE. On m1_n=0 and iorq_n=0, go to ACK.
  - ACK (one cycle): latch ack_idx=cur_idx; clear PEND[ack_idx]; set ISR[ack_idx]; int_n_o←1; int_ack_o←1; data_o←vector; go to HOLD.
  - HOLD: int_ack_o and data_o stay stable until m1_n=1, then int_ack_o←0 and go to IDLE.
- Vector = {VBASE[7:5], 1'b0, ack_idx[2:0], 1'b0}.
- Spurious ack (nothing eligible at the ACK cycle): vector = {VBASE[7:5], 5'b10000}; no PEND or ISR change.
- EOI: clears the lowest-index set ISR bit; no effect if ISR=0. An EOI write arriving in the same cycle as ACK applies before the new ISR set.
- int_ack_o=0: data_o returns register read data for reg_addr_i, combinational from registers.

Optional Feature:
IRQ_NESTING_EN
- Defined: a higher-priority source (lower index) may request while lower-priority sources are in service; blocking as defined above.
- Undefined: int_n_o is held high whenever ISR≠0; ISR logic is still present.

Test Plan:
- Reset, MASK=0x01, VBASE=0xA0, GIE=1; pulse irq_i[0] → int_n_o low 2 edges later; ack cycle → data_o=0xA0, int_ack_o=1 until m1_n high, ISR=0x01, PEND=0x00.
- irq_i[5] and irq_i[2] rise together, MASK=0xFF → first vector 0xA4; EOI; second vector 0xAA.
- With ISR=0x10 after ack of 4, raise irq_i[1] → int_n_o low with IRQ_NESTING_EN, stays high without; irq_i[6] stays blocked in both builds.
- irq_i[3] pending, MASK=0x08, then write MASK=0x00 while in REQ → int_n_o returns high, PEND reads 0x08.
- Write PEND=0x08 (W1C) in the same cycle as a new irq_i[3] edge → PEND reads 0x08. Hold wr_n low 3 cycles writing EOI with ISR=0x06 → ISR=0x04 only.
- Force ack when eligibility is zero → data_o=0xB0 (VBASE=0xA0); PEND and ISR unchanged; rst_i asserted during HOLD → int_ack_o=0 next edge.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: Z80 IM2 interrupt controller between the peripheral IRQ
// sources and the tv80s int_n input.
//
// Edge-captures up to NUM_SRC requests into PEND, masks them with MASK and
// the global enable GIE, picks the lowest eligible index (index 0 has the
// highest priority) and drives int_n_o. During the CPU acknowledge cycle
// (m1_n and iorq_n both low) it places the IM2 vector on data_o and raises
// int_ack_o until M1 ends. The serviced source stays in ISR until software
// writes EOI.
//
// Optional build macro: IRQ_NESTING_EN
//   defined   - a source may request while only higher-index sources are
//               in service.
//   undefined - no request is raised while any ISR bit is set.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous reset, active high
//   wr_n        CPU write strobe, active low
//   m1_n        CPU M1, active low
//   iorq_n      CPU IORQ, active low
//   reg_addr_i  register select (cpu_addr[2:0])
//   data_i      CPU write data
//   intc_cs     chip select from addr_decoder
//   data_o      register read data, or the vector while int_ack_o = 1
//   irq_i       peripheral requests, active high, synchronous to clk_i
//   int_n_o     interrupt request to the CPU, active low
//   int_ack_o   high while the vector is being presented
//
// Registers: 0 PEND (W1C), 1 MASK, 2 VBASE[7:5], 3 CTRL (W: bit7 GIE,
// bit0 EOI; R: {GIE, ~int_n_o, 3'b0, cur_idx}), 4 ISR (RO), 5..7 read 0.
module irq_controller #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_n,
  input  logic               m1_n,
  input  logic               iorq_n,
  input  logic [2:0]         reg_addr_i,
  input  logic [7:0]         data_i,
  input  logic               intc_cs,
  output logic [7:0]         data_o,
  input  logic [NUM_SRC-1:0] irq_i,
  output logic               int_n_o,
  output logic               int_ack_o
);

  localparam logic [8:0] SRC_TOP  = 9'd1 << NUM_SRC;
  localparam logic [7:0] SRC_MASK = 8'(SRC_TOP - 9'd1);

  typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  pend_q, mask_q, isr_q, irq_q, vec_q;
  logic [7:0]  pend_d, isr_d, irq_ext, edges, elig, take_mask, rd_data;
  logic [2:0]  vbase_q, cur_idx;
  logic        gie_q, wr_q, wr_act, wr_pulse, any_elig, found, take;
  logic        int_n_d, ack_d;
  logic [7:0]  vec_d;
  logic        wr_pend, wr_ctrl, wr_eoi;

  // One write per bus access: only the first cycle of a held strobe counts.
  assign wr_act   = intc_cs & ~wr_n;
  assign wr_pulse = wr_act & ~wr_q;
  assign wr_pend  = wr_pulse && (reg_addr_i == 3'd0);
  assign wr_ctrl  = wr_pulse && (reg_addr_i == 3'd3);
  assign wr_eoi   = wr_ctrl && data_i[0];

  always_comb begin
    irq_ext = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) irq_ext[i] = irq_i[i];
  end

  assign edges = irq_ext & ~irq_q;

`ifdef IRQ_NESTING_EN
  logic [7:0] blk;
  logic       run;

  // blk[i] is set when any in-service bit at index <= i is set.
  always_comb begin
    blk = '0;
    run = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      run    = run | isr_q[i];
      blk[i] = run;
    end
  end

  assign elig = pend_q & mask_q & {8{gie_q}} & ~blk;
`else
  assign elig = pend_q & mask_q & {8{gie_q}} & {8{isr_q == '0}};
`endif

  assign any_elig = |elig;

  always_comb begin
    cur_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (elig[i] && !found) begin
        cur_idx = 3'(i);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    int_n_d = int_n_o;
    ack_d   = int_ack_o;
    vec_d   = vec_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          int_n_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!any_elig) begin
          int_n_d = 1'b1;
          state_d = IDLE;
        end else if (!m1_n && !iorq_n) begin
          state_d = ACK;
        end
      end
      ACK: begin
        int_n_d = 1'b1;
        ack_d   = 1'b1;
        state_d = HOLD;
        take    = any_elig;
        vec_d   = any_elig ? {vbase_q, 1'b0, cur_idx, 1'b0}
                           : {vbase_q, 5'b10000};
      end
      HOLD: begin
        if (m1_n) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign take_mask = take ? (8'd1 << cur_idx) : '0;

  // A new edge overrides a same-cycle W1C or acknowledge clear; EOI
  // (isr & (isr-1) drops the lowest set bit) applies before the ACK set.
  always_comb begin
    pend_d = ((pend_q & ~(wr_pend ? data_i : 8'h00) & ~take_mask) | edges)
             & SRC_MASK;
    isr_d  = (wr_eoi ? (isr_q & (isr_q - 8'd1)) : isr_q) | take_mask;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      mask_q    <= '0;
      isr_q     <= '0;
      irq_q     <= '0;
      vbase_q   <= '0;
      gie_q     <= 1'b0;
      vec_q     <= '0;
      wr_q      <= 1'b0;
      int_n_o   <= 1'b1;
      int_ack_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      isr_q     <= isr_d;
      irq_q     <= irq_ext;
      vec_q     <= vec_d;
      wr_q      <= wr_act;
      int_n_o   <= int_n_d;
      int_ack_o <= ack_d;
      if (wr_pulse && (reg_addr_i == 3'd1)) mask_q  <= data_i & SRC_MASK;
      if (wr_pulse && (reg_addr_i == 3'd2)) vbase_q <= data_i[7:5];
      if (wr_ctrl) gie_q <= data_i[7];
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_addr_i)
      3'd0:    rd_data = pend_q;
      3'd1:    rd_data = mask_q;
      3'd2:    rd_data = {vbase_q, 5'b00000};
      3'd3:    rd_data = {gie_q, ~int_n_o, 3'b000, cur_idx};
      3'd4:    rd_data = isr_q;
      default: rd_data = '0;
    endcase
  end

  assign data_o = int_ack_o ? vec_q : rd_data;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: scoreboard bench for irq_controller. Stimulus tasks
// update a behavioural model and queue expected values; one monitor process
// compares vectors (on each int_ack_o rise) and probed signals.
module tb_irq_controller;

`ifdef IRQ_NESTING_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic       clk, rst_i, wr_n, m1_n, iorq_n, intc_cs;
  logic [2:0] reg_addr_i;
  logic [7:0] data_i, data_o, irq_i;
  logic       int_n_o, int_ack_o;

  irq_controller #(.NUM_SRC(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_n(wr_n), .m1_n(m1_n), .iorq_n(iorq_n),
    .reg_addr_i(reg_addr_i), .data_i(data_i), .intc_cs(intc_cs),
    .data_o(data_o), .irq_i(irq_i), .int_n_o(int_n_o), .int_ack_o(int_ack_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural model
  logic [7:0] m_pend, m_mask, m_isr;
  logic [2:0] m_vb;
  logic       m_gie;

  // scoreboard
  logic [7:0] q_val[$];
  int         q_sel[$];
  string      q_name[$];
  logic [7:0] v_q[$];
  logic       probe = 1'b0;
  logic       done  = 1'b0;
  int         total = 0;
  int         bad   = 0;

  function automatic int model_idx();
    for (int i = 0; i < 8; i++) begin
      if (m_gie && m_pend[i] && m_mask[i]) begin
        if (NEST ? ((int'(m_isr) % (1 << (i + 1))) == 0) : (m_isr == 8'h00))
          return i;
      end
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_vec();
    int idx;
    idx = model_idx();
    if (idx < 0) return {m_vb, 5'b10000};
    return {m_vb, 1'b0, 3'(idx), 1'b0};
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_isr = '0; m_vb = '0; m_gie = 1'b0;
  endtask

  task automatic model_eoi();
    for (int i = 0; i < 8; i++) begin
      if (m_isr[i]) begin
        m_isr[i] = 1'b0;
        break;
      end
    end
  endtask

  task automatic model_write(input logic [2:0] a, input logic [7:0] d);
    case (a)
      3'd0: m_pend = m_pend & ~d;
      3'd1: m_mask = d;
      3'd2: m_vb   = d[7:5];
      3'd3: begin
        m_gie = d[7];
        if (d[0]) model_eoi();
      end
      default: ;
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input int sel, input logic [7:0] v, input string nm);
    q_sel.push_back(sel);
    q_val.push_back(v);
    q_name.push_back(nm);
    probe = 1'b1;
    tick(1);
    probe = 1'b0;
  endtask

  task automatic expect_reg(input logic [2:0] a, input logic [7:0] v, input string nm);
    reg_addr_i = a;
    expect_sig(0, v, nm);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
    model_reset();
  endtask

  // Held for n cycles; irq_pat is driven during cycle irq_at only.
  task automatic wr_hold(input logic [2:0] a, input logic [7:0] d, input int n,
                         input int irq_at, input logic [7:0] irq_pat);
    intc_cs = 1'b1; wr_n = 1'b0; reg_addr_i = a; data_i = d;
    for (int c = 0; c < n; c++) begin
      irq_i = (c == irq_at) ? irq_pat : 8'h00;
      tick(1);
    end
    irq_i = 8'h00; intc_cs = 1'b0; wr_n = 1'b1;
    model_write(a, d);
    if (irq_at < n) m_pend = m_pend | irq_pat;
    tick(1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_hold(a, d, 1, 1, 8'h00);
  endtask

  task automatic eoi();
    wr(3'd3, {m_gie, 6'b0, 1'b1});
  endtask

  task automatic pulse(input logic [7:0] p);
    irq_i = p;
    tick(1);
    irq_i = 8'h00;
    m_pend = m_pend | p;
  endtask

  task automatic settle_check(input string nm);
    tick(3);
    expect_sig(1, {7'b0, model_idx() < 0}, nm);
  endtask

  task automatic wait_ack();
    for (int k = 0; k < 8; k++) begin
      if (int_ack_o) break;
      tick(1);
    end
  endtask

  task automatic do_ack();
    int idx;
    logic [7:0] v;
    idx = model_idx();
    v = model_vec();
    v_q.push_back(v);
    m1_n = 1'b0; iorq_n = 1'b0;
    wait_ack();
    expect_sig(2, 8'h01, "ack_high");
    expect_sig(0, v, "hold_vector");
    if (idx >= 0) begin
      m_pend[idx] = 1'b0;
      m_isr[idx]  = 1'b1;
    end
    m1_n = 1'b1; iorq_n = 1'b1;
    tick(1);
    expect_sig(2, 8'h00, "ack_low");
  endtask

  task automatic drain();
    for (int k = 0; k < 12; k++) begin
      settle_check("drain_int_n");
      if (model_idx() >= 0) do_ack();
      else if (m_isr != 8'h00) eoi();
      else break;
    end
  endtask

  // monitor
  initial begin
    int sel;
    logic [7:0] ev, act;
    string nm;
    logic ack_seen;
    ack_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (int_ack_o === 1'b1 && !ack_seen) begin
        total++;
        if (v_q.size() == 0) begin
          bad++;
          $display("FAIL vector: got %h required no acknowledge", data_o);
        end else begin
          ev = v_q.pop_front();
          if (data_o !== ev) begin
            bad++;
            $display("FAIL vector: got %h required %h", data_o, ev);
          end
        end
      end
      ack_seen = (int_ack_o === 1'b1);
      if (probe && q_val.size() != 0) begin
        sel = q_sel.pop_front();
        ev  = q_val.pop_front();
        nm  = q_name.pop_front();
        case (sel)
          1:       act = {7'b0, int_n_o};
          2:       act = {7'b0, int_ack_o};
          default: act = data_o;
        endcase
        total++;
        if (act !== ev) begin
          bad++;
          $display("FAIL %s: got %h required %h", nm, act, ev);
        end
      end
      if (done) begin
        total++;
        if (v_q.size() != 0 || q_val.size() != 0) begin
          bad++;
          $display("FAIL leftover: got %0d required 0", v_q.size() + q_val.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  // stimulus
  initial begin
    logic [7:0] r;
    rst_i = 1'b1; wr_n = 1'b1; m1_n = 1'b1; iorq_n = 1'b1; intc_cs = 1'b0;
    reg_addr_i = '0; data_i = '0; irq_i = '0;
    model_reset();
    do_reset();

    // reset state
    expect_sig(1, 8'h01, "rst_int_n");
    expect_sig(2, 8'h00, "rst_int_ack");
    for (int a = 0; a < 6; a++) expect_reg(3'(a), 8'h00, "rst_reg");
    wr(3'd6, 8'hFF);
    expect_reg(3'd6, 8'h00, "unmapped");

    // single source, int_n falls two edges after irq
    wr(3'd1, 8'h01); wr(3'd2, 8'hA0); wr(3'd3, 8'h80);
    expect_reg(3'd2, 8'hA0, "vbase");
    pulse(8'h01);
    expect_sig(1, 8'h01, "int_n_edge1");
    expect_sig(1, 8'h00, "int_n_edge2");
    do_ack();
    expect_reg(3'd4, 8'h01, "isr_after_ack");
    expect_reg(3'd0, 8'h00, "pend_after_ack");
    eoi();
    expect_reg(3'd4, 8'h00, "isr_after_eoi");

    // priority: 2 before 5
    wr(3'd1, 8'hFF);
    pulse(8'h24);
    settle_check("prio_int_n");
    expect_reg(3'd3, {m_gie, 1'b1, 3'b0, 3'd2}, "ctrl_cur_idx");
    do_ack();
    eoi();
    settle_check("prio_int_n2");
    do_ack();
    eoi();
    settle_check("prio_idle");

    // nesting
    pulse(8'h10);
    settle_check("nest_req4");
    do_ack();
    expect_reg(3'd4, m_isr, "nest_isr");
    pulse(8'h02);
    settle_check("nest_req1");
    if (model_idx() >= 0) do_ack();
    pulse(8'h40);
    settle_check("nest_req6");
    drain();

    // mask removed while requesting
    do_reset();
    wr(3'd2, 8'hA0); wr(3'd3, 8'h80); wr(3'd1, 8'h08);
    pulse(8'h08);
    settle_check("mask_req");
    wr(3'd1, 8'h00);
    settle_check("mask_drop");
    expect_reg(3'd0, 8'h08, "mask_pend");

    // W1C colliding with a new edge, then a held W1C
    wr_hold(3'd0, 8'h08, 1, 0, 8'h08);
    expect_reg(3'd0, m_pend, "w1c_edge");
    wr_hold(3'd0, 8'h08, 3, 1, 8'h08);
    expect_reg(3'd0, m_pend, "w1c_held");
    wr(3'd0, 8'h08);
    expect_reg(3'd0, 8'h00, "w1c_clear");

    // held EOI clears only one ISR bit
    wr(3'd1, 8'hFF);
    pulse(8'h04);
    settle_check("eoi_req2");
    do_ack();
    pulse(8'h02);
    settle_check("eoi_req1");
    if (model_idx() >= 0) do_ack();
    expect_reg(3'd4, m_isr, "eoi_isr_before");
    wr_hold(3'd3, 8'h81, 3, 3, 8'h00);
    expect_reg(3'd4, m_isr, "eoi_held");
    drain();

    // spurious acknowledge
    do_reset();
    wr(3'd2, 8'hA0); wr(3'd3, 8'h80); wr(3'd1, 8'h08);
    pulse(8'h08);
    settle_check("spur_req");
    m1_n = 1'b0; iorq_n = 1'b0;
    intc_cs = 1'b1; wr_n = 1'b0; reg_addr_i = 3'd1; data_i = 8'h00;
    tick(1);
    intc_cs = 1'b0; wr_n = 1'b1;
    model_write(3'd1, 8'h00);
    v_q.push_back(model_vec());
    wait_ack();
    expect_sig(0, 8'hB0, "spur_vector");
    m1_n = 1'b1; iorq_n = 1'b1;
    tick(2);
    expect_reg(3'd0, m_pend, "spur_pend");
    expect_reg(3'd4, m_isr, "spur_isr");

    // reset during HOLD
    wr(3'd1, 8'h08);
    settle_check("rst_hold_req");
    v_q.push_back(model_vec());
    m1_n = 1'b0; iorq_n = 1'b0;
    wait_ack();
    rst_i = 1'b1; m1_n = 1'b1; iorq_n = 1'b1;
    tick(1);
    rst_i = 1'b0;
    model_reset();
    expect_sig(2, 8'h00, "rst_hold_ack");
    expect_sig(1, 8'h01, "rst_hold_int_n");
    expect_reg(3'd0, 8'h00, "rst_hold_pend");

    // randomized
    for (int it = 0; it < 40; it++) begin
      wr(3'd1, 8'($urandom));
      if ($urandom_range(0, 3) == 0) wr(3'd2, 8'($urandom));
      wr(3'd3, {($urandom_range(0, 4) != 0), 7'b0});
      r = 8'($urandom) & 8'($urandom);
      pulse(r);
      if ($urandom_range(0, 3) == 0) wr(3'd0, 8'($urandom));
      settle_check("rnd_int_n");
      expect_reg(3'd0, m_pend, "rnd_pend");
      expect_reg(3'd3, {m_gie, model_idx() >= 0, 3'b0,
                        (model_idx() >= 0) ? 3'(model_idx()) : 3'd0}, "rnd_ctrl");
      if (model_idx() >= 0) begin
        do_ack();
        expect_reg(3'd4, m_isr, "rnd_isr");
      end
      if ($urandom_range(0, 3) != 0) eoi();
    end

    done = 1'b1;
  end

endmodule
